// File: rtl/im_mem_param.sv
// Parametrised instruction memory: one-cycle registered fetch port with fault
// detection, plus a valid/ready streaming loader that fills words from a base index.
module im_mem_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_req,
  input  logic [PC_W-1:0]          fetch_addr,
  output logic                     fetch_valid,
  output logic [WIDTH-1:0]         fetch_data,
  output logic                     fetch_fault,
  input  logic                     load_start,
  input  logic [$clog2(DEPTH)-1:0] load_base,
  input  logic [$clog2(DEPTH):0]   load_count,
  input  logic                     load_valid,
  input  logic [WIDTH-1:0]         load_data,
  output logic                     load_ready,
  output logic                     load_busy,
  output logic                     load_done,
  output logic                     loaded
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [AW:0] REM_LAST = {{AW{1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [AW-1:0]    ptr;
  logic [AW:0]      rem;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             accept;
  logic             fault;
  logic [AW-1:0]    idx;

  always_comb begin
    load_ready = (state == S_LOAD);
    load_busy  = (state != S_IDLE);
    load_done  = (state == S_DONE);
    accept     = load_ready && load_valid;
    idx        = fetch_addr[AW+1:2];
    // Fetches during LOAD always fault, so reads never race the loader's writes.
    fault      = (fetch_addr[1:0] != 2'b00)
              || ((fetch_addr >> (AW + 2)) != '0)
              || (state == S_LOAD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      ptr    <= '0;
      rem    <= '0;
      loaded <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_start) begin
            if (load_count != '0) begin
              state <= S_LOAD;
              ptr   <= load_base;
              rem   <= load_count;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            ptr <= ptr + 1'b1;
            rem <= rem - 1'b1;
            if (rem == REM_LAST) state <= S_DONE;
          end
        end
        S_DONE: begin
          loaded <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset so words survive an aborted load.
  always_ff @(posedge clk) begin
    if (accept) mem[ptr] <= load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      fetch_fault <= 1'b0;
    end else begin
      fetch_valid <= fetch_req;
      if (fetch_req) begin
        if (fault) begin
          fetch_data  <= '0;
          fetch_fault <= 1'b1;
        end else begin
          fetch_data  <= mem[idx];
          fetch_fault <= 1'b0;
        end
      end else begin
        fetch_fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_im_mem_param.sv
// Bench for im_mem_param: directed loader/fetch scenarios followed by randomized
// loads and fetch bursts, checked against an array model of the memory.
module tb_im_mem_param;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int PC_W  = 32;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             fetch_req;
  logic [PC_W-1:0]  fetch_addr;
  logic             fetch_valid;
  logic [WIDTH-1:0] fetch_data;
  logic             fetch_fault;
  logic             load_start;
  logic [AW-1:0]    load_base;
  logic [AW:0]      load_count;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             load_busy;
  logic             load_done;
  logic             loaded;

  im_mem_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_data(fetch_data), .fetch_fault(fetch_fault),
    .load_start(load_start), .load_base(load_base), .load_count(load_count),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_busy(load_busy), .load_done(load_done), .loaded(loaded)
  );

  always #5 clk = ~clk;

  int unsigned      vectors = 0;
  int unsigned      miscompares = 0;
  logic [WIDTH-1:0] model_mem [DEPTH];
  bit               known [DEPTH];
  logic [WIDTH-1:0] ld_words [DEPTH];
  logic [WIDTH-1:0] last_data;
  bit               last_known;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch one address; the caller decides whether fetch_req stays high afterwards.
  task automatic fetch_one(input logic [PC_W-1:0] a, input bit hold);
    bit exp_fault;
    int unsigned i;
    fetch_req  = 1'b1;
    fetch_addr = a;
    exp_fault  = (a % 4 != 0) || (a >= DEPTH * 4);
    i = (a / 4) % DEPTH;
    step();
    chk("fetch_valid", fetch_valid, 1);
    chk("fetch_fault", fetch_fault, exp_fault);
    if (exp_fault) begin
      chk("fetch_data_fault", fetch_data, 0);
      last_data = '0; last_known = 1'b1;
    end else if (known[i]) begin
      chk("fetch_data", fetch_data, model_mem[i]);
      last_data = model_mem[i]; last_known = 1'b1;
    end else begin
      last_known = 1'b0;
    end
    if (!hold) fetch_req = 1'b0;
  endtask

  task automatic fetch_idle();
    fetch_req = 1'b0;
    step();
    chk("idle_valid", fetch_valid, 0);
    chk("idle_fault", fetch_fault, 0);
    if (last_known) chk("idle_data_hold", fetch_data, last_data);
  endtask

  task automatic do_load(input int base, input int count, input int stall_at,
                         input int stall_len, input bit fetch_in_stall,
                         input bit restart_in_stall, input bit rnd_gaps);
    int k = 0;
    int stall = 0;
    int guard = 0;
    load_start = 1'b1;
    load_base  = AW'(base);
    load_count = (AW+1)'(count);
    step();
    load_start = 1'b0;
    if (count != 0) begin
      while (k < count && guard < 200) begin
        guard++;
        chk("ready_in_load", load_ready, 1);
        chk("busy_in_load", load_busy, 1);
        chk("no_early_done", load_done, 0);
        if (k == stall_at && stall < stall_len) begin
          stall++;
          load_valid = 1'b0;
          fetch_req  = fetch_in_stall && stall == 1;
          fetch_addr = '0;
          if (restart_in_stall && stall == 2) begin
            load_start = 1'b1;
            load_base  = AW'(base + 7);
            load_count = 5'd2;
          end
          step();
          load_start = 1'b0;
          if (fetch_in_stall && stall == 1) begin
            chk("load_fetch_valid", fetch_valid, 1);
            chk("load_fetch_fault", fetch_fault, 1);
            chk("load_fetch_data", fetch_data, 0);
            last_data = '0; last_known = 1'b1;
          end
          fetch_req = 1'b0;
        end else if (rnd_gaps && $urandom_range(0, 3) == 0) begin
          load_valid = 1'b0;
          step();
        end else begin
          load_valid = 1'b1;
          load_data  = ld_words[k];
          model_mem[(base + k) % DEPTH] = ld_words[k];
          known[(base + k) % DEPTH] = 1'b1;
          k++;
          step();
          load_valid = 1'b0;
        end
      end
      chk("load_beats", k, count);
    end
    chk("done_pulse", load_done, 1);
    chk("done_busy", load_busy, 1);
    chk("done_not_ready", load_ready, 0);
    step();
    chk("done_cleared", load_done, 0);
    chk("loaded_set", loaded, 1);
    chk("idle_not_busy", load_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0;
    load_base = '0; load_count = '0; load_valid = 1'b0; load_data = '0;
    last_data = '0; last_known = 1'b1;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    repeat (2) step();
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_fetch_data", fetch_data, 0);
    chk("rst_fetch_fault", fetch_fault, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_load_busy", load_busy, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_loaded", loaded, 0);
    reset = 1'b1;
    step();

    // Basic load of four words with valid held high, then back-to-back fetches.
    for (int i = 0; i < 4; i++) ld_words[i] = 32'hA000_0001 + i;
    do_load(0, 4, -1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) fetch_one(PC_W'(i * 4), i != 3);
    fetch_idle();

    // Wrap past the top of the array.
    ld_words[0] = 32'h11; ld_words[1] = 32'h22; ld_words[2] = 32'h33; ld_words[3] = 32'h44;
    do_load(14, 4, -1, 0, 0, 0, 0);
    fetch_one(32'h38, 1);
    fetch_one(32'h04, 0);
    fetch_one(32'h06, 1);
    fetch_one(32'h40, 0);
    fetch_idle();

    // Stalled load with a fetch issued mid-load.
    for (int i = 0; i < 3; i++) ld_words[i] = 32'hBEEF_0000 + i;
    do_load(6, 3, 1, 5, 1, 0, 0);
    for (int i = 6; i < 9; i++) fetch_one(PC_W'(i * 4), 0);

    // load_start mid-load must not disturb the running load.
    for (int i = 0; i < 4; i++) ld_words[i] = 32'hC0DE_0000 + i;
    do_load(8, 4, 2, 3, 0, 1, 0);
    for (int i = 8; i < 12; i++) fetch_one(PC_W'(i * 4), 1);
    fetch_one(32'h3C, 1);
    fetch_one(32'h00, 0);
    fetch_idle();

    // Reset after two of four beats: abort, keep written words, clear loaded.
    load_start = 1'b1; load_base = 4'd4; load_count = 5'd4;
    step();
    load_start = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h8;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = 32'hD00D_0000 + i;
      model_mem[4 + i] = load_data; known[4 + i] = 1'b1;
      step();
    end
    load_data = 32'hDEAD_DEAD;
    chk("pre_rst_fault", fetch_fault, 1);
    chk("pre_rst_busy", load_busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_fetch_valid", fetch_valid, 0);
    chk("arst_fetch_fault", fetch_fault, 0);
    chk("arst_load_ready", load_ready, 0);
    chk("arst_load_busy", load_busy, 0);
    chk("arst_loaded", loaded, 0);
    fetch_req = 1'b0; load_valid = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    chk("post_rst_loaded", loaded, 0);
    chk("post_rst_busy", load_busy, 0);
    do_load(3, 0, -1, 0, 0, 0, 0);
    for (int i = 4; i < 8; i++) fetch_one(PC_W'(i * 4), 1);
    fetch_idle();

    // Randomized loads (including full-depth wrap) and fetch bursts.
    for (int r = 0; r < 12; r++) begin
      int base;
      int cnt;
      base = $urandom_range(0, DEPTH - 1);
      cnt  = (r == 0) ? DEPTH : $urandom_range(0, DEPTH);
      for (int i = 0; i < DEPTH; i++) ld_words[i] = $urandom;
      do_load(base, cnt, -1, 0, 0, 0, 1);
      for (int f = 0; f < 8; f++) begin
        int unsigned sel;
        int unsigned idx;
        logic [PC_W-1:0] a;
        sel = $urandom_range(0, 9);
        idx = $urandom_range(0, DEPTH - 1);
        if (sel < 7)       a = PC_W'(idx * 4);
        else if (sel == 7) a = PC_W'(idx * 4 + $urandom_range(1, 3));
        else if (sel == 8) a = PC_W'(($urandom_range(1, 1000) << 6) + idx * 4);
        else               a = 32'hFFFF_FFFC;
        fetch_one(a, f != 7);
      end
      fetch_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/im_mem_param.md
Name: im_mem_param

Overview:
- Parametrised instruction memory: the next generation of the fixed 16x32 IM.
- Configurable word width and depth.
- Synchronous fetch port with one-cycle registered read, plus fault detection for misaligned, out-of-range or busy fetches.
- Streaming program-loader port with a valid/ready handshake, controlled by an FSM, that writes consecutive words from a base index with wrap-around.
- Sits between the PC/fetch stage and the test-harness program loader.

Parameters:
- WIDTH, 32, instruction word width in bits (>=8).
- DEPTH, 16, number of words; power of 2, >=2. AW = log2(DEPTH) is derived internally.
- PC_W, 32, fetch byte-address width (PC_W >= AW+2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request this cycle.
- fetch_addr  in  PC_W  byte address (PC).
- fetch_valid  out  1  registered; response valid.
- fetch_data  out  WIDTH  registered instruction word.
- fetch_fault  out  1  registered; the response is a fault.
- load_start  in  1  begin a program load (sampled in IDLE only).
- load_base  in  AW  first word index to write.
- load_count  in  AW+1  number of words to write (0..DEPTH).
- load_valid  in  1  load_data is valid.
- load_data  in  WIDTH  word to write.
- load_ready  out  1  loader accepts a word this cycle.
- load_busy  out  1  FSM is not in IDLE.
- load_done  out  1  one-cycle pulse when a load completes.
- loaded  out  1  sticky; at least one load has completed since reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; write pointer and remaining counter go to 0.
  - fetch_valid=0, fetch_data=0, fetch_fault=0, load_ready=0, load_busy=0, load_done=0, loaded=0.
  - Memory array is not cleared; contents are undefined until loaded.
  - Reset mid-load aborts the load. Already-written words are retained and loaded stays 0.
- FSM states: IDLE, LOAD, DONE.
  - IDLE, load_start=1, load_count!=0: go to LOAD. ptr<=load_base, rem<=load_count.
  - IDLE, load_start=1, load_count==0: go to DONE with no writes.
  - LOAD: load_ready=1 combinationally. On load_valid&&load_ready, mem[ptr]<=load_data, ptr<=(ptr+1) mod DEPTH, rem<=rem-1.
  - LOAD: when the beat with rem==1 is accepted, go to DONE.
  - LOAD: load_valid=0 stalls with no timeout.
  - DONE: load_done=1 for exactly one cycle, loaded<=1, then go to IDLE.
  - load_start is ignored outside IDLE.
  - load_busy=1 in LOAD and DONE.
  - load_count==DEPTH writes every word exactly once, wrapping past DEPTH-1 to 0.
- Fetch:
  - Latency is one cycle. fetch_valid(t+1)=fetch_req(t).
  - Index = fetch_addr[AW+1:2].
  - fault = fetch_addr[1:0]!=0, OR fetch_addr[PC_W-1:AW+2]!=0, OR state==LOAD.
  - No fault: fetch_data<=mem[index], fetch_fault<=0.
  - Fault: fetch_data<=0, fetch_fault<=1.
  - fetch_req=0: fetch_valid<=0, fetch_fault<=0, fetch_data holds its previous value.
  - Fetch in DONE is permitted and returns the newly written data, because all writes complete before DONE.
  - Back-to-back fetches are supported at one per cycle.
  - Fetch in LOAD always faults, so there is never a read/write collision.

Test Plan:
- Reset low, then release; load base=0, count=4, words 0xA0000001..0xA0000004 with load_valid held high -> load_ready high for 4 cycles, then load_done pulses 1 cycle and loaded=1. Fetches of addr 0x0, 0x4, 0x8, 0xC return those words one cycle after each request, fault=0.
- Load base=14, count=4 (DEPTH=16), words 0x11, 0x22, 0x33, 0x44 -> words land at indices 14, 15, 0, 1 (wrap). Fetch 0x38 returns 0x11; fetch 0x4 returns 0x44.
- Fetch addr 0x6 (misaligned) and addr 0x40 (out of range) -> fetch_valid=1, fetch_fault=1, fetch_data=0.
- Start a load of count=3 and drop load_valid for 5 cycles after the first beat; issue fetch 0x0 during LOAD -> the load stalls with load_busy=1, the fetch responds with fault=1 and data=0, and load_done fires only after the 3rd beat.
- Assert reset low after 2 of 4 beats -> all outputs go to 0 immediately and state returns to IDLE. A subsequent load of count=0 gives load_done pulse, loaded=1 and no memory change.
- Assert load_start with new parameters during LOAD -> it is ignored, and the original count and base complete unchanged.
